// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the FIFO read adapter.
// Default widths and the skid-buffer occupancy encoding.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: two-entry in-order buffer.
// Entry 0 is always the head; the state value doubles as the count.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int W = FIFO_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;

    // pop shifts the tail forward; push lands behind whatever survives
    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    ent0_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ent0_d = push_data;
                end else if (push) begin
                    ent1_d  = push_data;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    if (push) begin
                        ent1_d = push_data;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // buffer registers, cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            state_q <= state_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign head  = ent0_q;
    assign count = state_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter: turns a 1-cycle-latency FIFO read port
// into a valid/ready stream backed by a two-entry skid buffer.
module fifo_rd_adapter
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  err_underflow
);

    logic                 inflight_q, inflight_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] words_q, words_d;
    logic                 pop, push, rd_en;
    logic [1:0]           count;
    logic [2:0]           room;
    logic [FIFO_WIDTH-1:0] head;

    fifo_skid_buf #(
        .W(FIFO_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // issue a read only if its capture next cycle is sure of a free slot
    always_comb begin
        pop   = (count != 2'd0) && m_ready;
        push  = inflight_q && !fifo_underflow;
        room  = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
        rd_en = rst_n && !fifo_empty && (room < 3'd2);
    end

    // next values for the in-flight flag, sticky error and transfer count
    always_comb begin
        inflight_d = rd_en;
        err_d      = err_q | (inflight_q & fifo_underflow);
        words_d    = words_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    end

    // control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    assign fifo_rd_en    = rd_en;
    assign m_valid       = (count != 2'd0);
    assign m_data        = head;
    assign occupancy     = count;
    assign words_out     = words_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// tb_fifo_rd_adapter: queue-based model of upstream FIFO and adapter,
// directed scenarios followed by randomized traffic and a mid-run reset.
module tb_fifo_rd_adapter;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow = 1'b0;
    logic [W-1:0]  fifo_data_out = '0;
    logic          m_ready = 1'b0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] words_out;
    logic          err_underflow;

    fifo_rd_adapter #(
        .FIFO_WIDTH(W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_underflow(fifo_underflow),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .occupancy     (occupancy),
        .words_out     (words_out),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dlv_q[$];
    int           dlv_cyc[$];

    int           m_words = 0;
    bit           m_err = 0;
    bit           infl = 0;
    logic [W-1:0] infl_word = '0;
    bit           infl_uf = 0;
    int           uf_at = -1;
    bit           rnd_uf = 0;
    int           rd_count = 0;
    int           cyc = 0;
    int           rdy_mode = 1;
    bit           tog = 1;
    int           dut_first_rd = -1;
    int           dut_first_valid = -1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic clear_log();
        dlv_q.delete();
        dlv_cyc.delete();
        rd_count        = 0;
        dut_first_rd    = -1;
        dut_first_valid = -1;
    endtask

    task automatic cycle();
        int sz;
        bit pop;
        bit exp_rd;
        @(negedge clk);
        cyc++;
        if (infl) begin
            fifo_data_out  = infl_word;
            fifo_underflow = infl_uf;
        end else begin
            fifo_data_out  = W'($urandom);
            fifo_underflow = rnd_uf ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
        case (rdy_mode)
            0: m_ready = 1'($urandom_range(0, 1));
            1: m_ready = 1'b1;
            2: m_ready = 1'b0;
            default: begin
                m_ready = tog;
                tog = ~tog;
            end
        endcase
        fifo_empty = (src_q.size() == 0);
        #1;
        sz = exp_q.size();
        chk("occupancy", occupancy, sz);
        chk("occ_max", occupancy <= 2, 1);
        chk("m_valid", m_valid, sz > 0);
        if (sz > 0) chk("m_data", m_data, exp_q[0]);
        chk("words_out", words_out, m_words);
        chk("err_underflow", err_underflow, m_err);
        pop = (sz > 0) && m_ready;
        exp_rd = !fifo_empty && (sz + int'(infl) - int'(pop) < 2);
        chk("fifo_rd_en", fifo_rd_en, exp_rd);
        if (fifo_rd_en === 1'b1 && dut_first_rd < 0) dut_first_rd = cyc;
        if (m_valid === 1'b1 && dut_first_valid < 0) dut_first_valid = cyc;
        if (pop) begin
            dlv_q.push_back(exp_q.pop_front());
            dlv_cyc.push_back(cyc);
            m_words = (m_words + 1) % (1 << CW);
        end
        if (infl) begin
            if (infl_uf) m_err = 1'b1;
            else exp_q.push_back(infl_word);
        end
        infl = exp_rd;
        if (exp_rd) begin
            rd_count++;
            infl_word = src_q.pop_front();
            infl_uf = (rd_count == uf_at) ||
                      (rnd_uf && $urandom_range(0, 15) == 0);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        fifo_empty = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_words_out", words_out, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_rd_en_hold", fifo_rd_en, 0);
        end
        fifo_empty     = 1'b1;
        fifo_underflow = 1'b0;
        rst_n          = 1'b1;
        exp_q.delete();
        m_words = 0;
        m_err   = 1'b0;
        infl    = 1'b0;
    endtask

    initial begin
        pulse_reset();

        // idle with an empty FIFO
        clear_log();
        repeat (10) begin
            cycle();
            chk("idle_rd_en", fifo_rd_en, 0);
            chk("idle_valid", m_valid, 0);
            chk("idle_occ", occupancy, 0);
        end

        // streaming burst of 8 words
        clear_log();
        for (int i = 1; i <= 8; i++) src_q.push_back(W'(i));
        rdy_mode = 1;
        repeat (14) cycle();
        chk("burst_count", dlv_q.size(), 8);
        for (int i = 0; i < dlv_q.size(); i++) begin
            chk("burst_data", dlv_q[i], i + 1);
            chk("burst_consec", dlv_cyc[i], dlv_cyc[0] + i);
        end
        chk("burst_latency", dut_first_valid - dut_first_rd, 2);
        chk("burst_words", words_out, 8);

        // backpressure: only two reads while stalled
        pulse_reset();
        clear_log();
        for (int i = 1; i <= 5; i++) src_q.push_back(W'(16'h0A00 + i));
        rdy_mode = 2;
        repeat (8) cycle();
        chk("stall_reads", rd_count, 2);
        chk("stall_occ", occupancy, 2);
        chk("stall_valid", m_valid, 1);
        chk("stall_head", m_data, 16'h0A01);
        rdy_mode = 1;
        repeat (10) cycle();
        chk("stall_count", dlv_q.size(), 5);
        for (int i = 0; i < dlv_q.size(); i++)
            chk("stall_order", dlv_q[i], 16'h0A01 + i);

        // alternating ready
        clear_log();
        for (int i = 1; i <= 6; i++) src_q.push_back(W'(16'h0B00 + i));
        rdy_mode = 3;
        tog = 1'b1;
        repeat (20) cycle();
        chk("toggle_count", dlv_q.size(), 6);
        for (int i = 0; i < dlv_q.size(); i++)
            chk("toggle_order", dlv_q[i], 16'h0B01 + i);

        // underflow on the second capture
        pulse_reset();
        clear_log();
        for (int i = 1; i <= 3; i++) src_q.push_back(W'(16'h0C00 + i));
        rdy_mode = 1;
        uf_at = 2;
        repeat (10) cycle();
        uf_at = -1;
        chk("uf_count", dlv_q.size(), 2);
        if (dlv_q.size() == 2) begin
            chk("uf_first", dlv_q[0], 16'h0C01);
            chk("uf_second", dlv_q[1], 16'h0C03);
        end
        chk("uf_err", err_underflow, 1);
        src_q.push_back(16'h0C10);
        src_q.push_back(16'h0C11);
        repeat (8) cycle();
        chk("uf_sticky", err_underflow, 1);

        // reset while full (also clears the sticky error)
        pulse_reset();
        clear_log();
        for (int i = 1; i <= 4; i++) src_q.push_back(W'(16'h0D00 + i));
        rdy_mode = 2;
        repeat (6) cycle();
        chk("full_occ", occupancy, 2);
        pulse_reset();

        // randomized traffic with a reset in the middle
        rdy_mode = 0;
        rnd_uf = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) src_q.push_back(W'($urandom));
            end
            if (i == 300) pulse_reset();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
